// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared state, opcode, aluOp and ALUcontrol encodings for the multicycle RV32I controller and ALU
package multicycle_controller_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: controller<->datapath bundle; inputs op/funct3/funct7b5/zero, outputs selects, enables, halt, state, instrCount
interface multicycle_controller_if #(parameter int CNT_WIDTH = 32);
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 funct7b5;
  logic                 zero;
  logic                 pcWrite;
  logic                 adrSrc;
  logic                 irWrite;
  logic                 memWrite;
  logic                 regWrite;
  logic [1:0]           resSrc;
  logic [1:0]           aluSrcA;
  logic [1:0]           aluSrcB;
  logic [1:0]           inmSrc;
  logic [2:0]           ALUcontrol;
  logic                 halt;
  logic [3:0]           state;
  logic [CNT_WIDTH-1:0] instrCount;
  modport master (
    input  op, funct3, funct7b5, zero,
    output pcWrite, adrSrc, irWrite, memWrite, regWrite, resSrc, aluSrcA, aluSrcB,
           inmSrc, ALUcontrol, halt, state, instrCount
  );
  modport slave (
    output op, funct3, funct7b5, zero,
    input  pcWrite, adrSrc, irWrite, memWrite, regWrite, resSrc, aluSrcA, aluSrcB,
           inmSrc, ALUcontrol, halt, state, instrCount
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps aluOp/funct3/funct7b5/op5 to the 3-bit ALUcontrol code
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] ALUcontrol
);
  logic [2:0] fn_ctl;
  always_comb begin
    fn_ctl = funct3 == 3'b000 ? ((op5 & funct7b5) ? ALU_SUB : ALU_ADD) :
             funct3 == 3'b010 ? ALU_SLT :
             funct3 == 3'b110 ? ALU_OR  :
             funct3 == 3'b111 ? ALU_AND : ALU_ADD;
    ALUcontrol = aluOp == ALUOP_SUB ? ALU_SUB :
                 aluOp == ALUOP_FN  ? fn_ctl  : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the multicycle RV32I datapath; clk/reset plus bus (decoded fields in, selects/enables/halt/state/instrCount out)
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           alu_op, res_src, src_a, src_b;
  logic                 pc_we, ir_we, mem_we, reg_we, adr_src, retire;
  always_comb begin
    state_d = S_FETCH;
    alu_op  = ALUOP_ADD;
    res_src = 2'b00;
    src_a   = 2'b00;
    src_b   = 2'b00;
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    mem_we  = 1'b0;
    reg_we  = 1'b0;
    adr_src = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        src_b   = 2'b10;
        res_src = 2'b10;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        src_a   = 2'b01;
        src_b   = 2'b01;
        state_d = (bus.op == OP_LW || bus.op == OP_SW) ? S_MEMADR :
                  bus.op == OP_R   ? S_EXECUTER :
                  bus.op == OP_I   ? S_EXECUTEI :
                  bus.op == OP_BEQ ? S_BEQ :
                  bus.op == OP_JAL ? S_JAL : S_TRAP;
      end
      S_MEMADR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        state_d = bus.op == OP_LW ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res_src = 2'b01;
        reg_we  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_we  = 1'b1;
      end
      S_EXECUTER: begin
        src_a   = 2'b10;
        alu_op  = ALUOP_FN;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_op  = ALUOP_FN;
        state_d = S_ALUWB;
      end
      S_ALUWB: reg_we = 1'b1;
      S_BEQ: begin
        src_a  = 2'b10;
        alu_op = ALUOP_SUB;
        pc_we  = bus.zero;
      end
      S_JAL: begin
        src_a   = 2'b01;
        src_b   = 2'b10;
        pc_we   = 1'b1;
        state_d = S_ALUWB;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end
  assign retire = state_q == S_MEMWB || state_q == S_MEMWRITE || state_q == S_ALUWB || state_q == S_BEQ;
  assign cnt_d  = retire ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    state_q <= reset ? S_FETCH : state_d;
    cnt_q   <= reset ? '0 : cnt_d;
  end
  assign bus.pcWrite    = pc_we & ~reset;
  assign bus.irWrite    = ir_we & ~reset;
  assign bus.memWrite   = mem_we & ~reset;
  assign bus.regWrite   = reg_we & ~reset;
  assign bus.adrSrc     = adr_src;
  assign bus.resSrc     = res_src;
  assign bus.aluSrcA    = src_a;
  assign bus.aluSrcB    = src_b;
  assign bus.halt       = state_q == S_TRAP;
  assign bus.state      = state_q;
  assign bus.instrCount = cnt_q;
  assign bus.inmSrc     = bus.op == OP_SW  ? 2'b01 :
                          bus.op == OP_BEQ ? 2'b10 :
                          bus.op == OP_JAL ? 2'b11 : 2'b00;
  alu_decoder u_alu_decoder (
    .aluOp      (alu_op),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .op5        (bus.op[5]),
    .ALUcontrol (bus.ALUcontrol)
  );
endmodule
